// File: rtl/systolic_skew_feeder.sv
// Front end for an N x N systolic multiply array: captures A/B, clears the array, feeds skewed vectors, returns out_matrix.
// Optional SKEW_FEEDER_B_COLMAJOR_EN: mat_b is taken column-major instead of row-major.
module systolic_skew_feeder #(
  parameter int MATRIX_SIZE  = 3,
  parameter int DATA_SIZE    = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] mat_a   [0:MATRIX_SIZE*MATRIX_SIZE-1],
  input  logic [DATA_SIZE-1:0] mat_b   [0:MATRIX_SIZE*MATRIX_SIZE-1],
  output logic                 arr_clr,
  output logic [DATA_SIZE-1:0] arr_a   [0:MATRIX_SIZE-1],
  output logic [DATA_SIZE-1:0] arr_b   [0:MATRIX_SIZE-1],
  input  logic [DATA_SIZE-1:0] arr_sum [0:MATRIX_SIZE*MATRIX_SIZE-1],
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [DATA_SIZE-1:0] result  [0:MATRIX_SIZE*MATRIX_SIZE-1]
);

  localparam int N   = MATRIX_SIZE;
  localparam int NN  = N * N;
  localparam int TW  = $clog2(3 * N) + 1;
  localparam int DCW = $clog2(DRAIN_CYCLES) + 1;
  localparam int IW  = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'(3 * N - 3);
  localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t               state, state_next;
  logic [TW-1:0]        t, t_next;
  logic [DCW-1:0]       d, d_next;
  logic [DATA_SIZE-1:0] a_buf  [0:NN-1];
  logic [DATA_SIZE-1:0] b_buf  [0:NN-1];
  logic [DATA_SIZE-1:0] a_feed [0:N-1];
  logic [DATA_SIZE-1:0] b_feed [0:N-1];

  // Buffer index of B[row][col] for the configured storage order.
  function automatic logic [IW-1:0] b_index(input int row, input int col);
`ifdef SKEW_FEEDER_B_COLMAJOR_EN
    return IW'(col * N + row);
`else
    return IW'(row * N + col);
`endif
  endfunction

  assign in_ready     = (state == IDLE);
  assign arr_clr      = (state == CLEAR);
  assign result_valid = (state == DONE);

  always_comb begin
    state_next = state;
    t_next     = t;
    d_next     = d;
    case (state)
      IDLE:  if (in_valid) state_next = CLEAR;
      CLEAR: begin
        state_next = FEED;
        t_next     = '0;
      end
      FEED: begin
        if (t == T_LAST) begin
          state_next = DRAIN;
          t_next     = '0;
          d_next     = '0;
        end else begin
          t_next = t + 1'b1;
        end
      end
      DRAIN: begin
        if (d == D_LAST) begin
          state_next = DONE;
          d_next     = '0;
        end else begin
          d_next = d + 1'b1;
        end
      end
      DONE:    if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Skew is computed for the step being entered so the registered outputs line up with FEED cycle t.
  always_comb begin
    int k;
    k = 0;
    for (int i = 0; i < N; i++) begin
      a_feed[i] = '0;
      b_feed[i] = '0;
    end
    if (state_next == FEED) begin
      for (int i = 0; i < N; i++) begin
        k = int'(t_next) - i;
        if (k >= 0 && k < N) begin
          a_feed[i] = a_buf[IW'(i * N + k)];
          b_feed[i] = b_buf[b_index(k, i)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_buf <= mat_a;
      b_buf <= mat_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      t      <= '0;
      d      <= '0;
      arr_a  <= '{default: '0};
      arr_b  <= '{default: '0};
      result <= '{default: '0};
    end else begin
      state <= state_next;
      t     <= t_next;
      d     <= d_next;
      arr_a <= a_feed;
      arr_b <= b_feed;
      if (state == DRAIN && state_next == DONE) result <= arr_sum;
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: drives it into an output-stationary array model and scoreboards the products.
module tb_systolic_skew_feeder;

  localparam int N  = 3;
  localparam int D  = 8;
  localparam int NN = N * N;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, arr_clr, result_valid, result_ready;
  logic [D-1:0] mat_a  [0:NN-1];
  logic [D-1:0] mat_b  [0:NN-1];
  logic [D-1:0] arr_a  [0:N-1];
  logic [D-1:0] arr_b  [0:N-1];
  logic [D-1:0] acc    [0:NN-1];
  logic [D-1:0] result [0:NN-1];

  int ga [0:NN-1];
  int gb [0:NN-1];
  logic [NN*D-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.MATRIX_SIZE(N), .DATA_SIZE(D), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mat_a(mat_a), .mat_b(mat_b), .arr_clr(arr_clr), .arr_a(arr_a), .arr_b(arr_b),
    .arr_sum(acc), .result_valid(result_valid), .result_ready(result_ready), .result(result)
  );

  // Output-stationary array: A flows right, B flows down, each PE accumulates in place.
  logic [D-1:0] ain [0:N-1][0:N-1];
  logic [D-1:0] bin [0:N-1][0:N-1];
  logic [D-1:0] ar  [0:N-1][0:N-1];
  logic [D-1:0] br  [0:N-1][0:N-1];

  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ain[i][j] = (j == 0) ? arr_a[i] : ar[i][(j > 0) ? j - 1 : 0];
        bin[i][j] = (i == 0) ? arr_b[j] : br[(i > 0) ? i - 1 : 0][j];
      end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (reset || arr_clr) begin
          ar[i][j]    <= '0;
          br[i][j]    <= '0;
          acc[i*N+j]  <= '0;
        end else begin
          ar[i][j]    <= ain[i][j];
          br[i][j]    <= bin[i][j];
          acc[i*N+j]  <= acc[i*N+j] + ain[i][j] * bin[i][j];
        end
  end

  function automatic logic [NN*D-1:0] matmul();
    logic [NN*D-1:0] p;
    int s;
    p = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += ga[r*N+k] * gb[k*N+c];
        p[(NN-1-(r*N+c))*D +: D] = s[D-1:0];
      end
    return p;
  endfunction

  function automatic logic [NN*D-1:0] pack_res();
    logic [NN*D-1:0] p;
    for (int e = 0; e < NN; e++) p[(NN-1-e)*D +: D] = result[e];
    return p;
  endfunction

  function automatic logic [N*D-1:0] pack_a();
    logic [N*D-1:0] p;
    for (int e = 0; e < N; e++) p[(N-1-e)*D +: D] = arr_a[e];
    return p;
  endfunction

  function automatic logic [N*D-1:0] pack_b();
    logic [N*D-1:0] p;
    for (int e = 0; e < N; e++) p[(N-1-e)*D +: D] = arr_b[e];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [NN*D-1:0] obs, input logic [NN*D-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_a_seq(input int base);
    for (int e = 0; e < NN; e++) ga[e] = base + e;
  endtask

  task automatic set_b_seq(input int base);
    for (int e = 0; e < NN; e++) gb[e] = base + e;
  endtask

  task automatic set_b_ident();
    for (int e = 0; e < NN; e++) gb[e] = (e / N == e % N) ? 1 : 0;
  endtask

  task automatic set_fill(input int av, input int bv);
    for (int e = 0; e < NN; e++) begin
      ga[e] = av;
      gb[e] = bv;
    end
  endtask

  task automatic load();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mat_a[r*N+c] = ga[r*N+c][D-1:0];
`ifdef SKEW_FEEDER_B_COLMAJOR_EN
        mat_b[c*N+r] = gb[r*N+c][D-1:0];
`else
        mat_b[r*N+c] = gb[r*N+c][D-1:0];
`endif
      end
  endtask

  task automatic accept(input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", {71'b0, in_ready}, 72'd1);
    load();
    if (push) exp_q.push_back(matmul());
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag);
    logic [NN*D-1:0] e;
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk(tag, pack_res(), e);
  endtask

  task automatic finish_txn(input string tag);
    int lat, clr;
    lat = 0;
    clr = 0;
    while (!result_valid && lat < 60) begin
      if (arr_clr) clr++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 72'(lat), 72'd11);
    chk({tag, "_clr_pulses"}, 72'(clr), 72'd1);
    check_result({tag, "_result"});
  endtask

  task automatic release_result();
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
    chk("valid_drop_after_accept", {71'b0, result_valid}, 72'd0);
    chk("in_ready_after_accept", {71'b0, in_ready}, 72'd1);
  endtask

  initial begin
    logic [NN*D-1:0] held;
    reset = 1'b1;
    in_valid = 1'b0;
    result_ready = 1'b0;
    for (int e = 0; e < NN; e++) begin
      mat_a[e] = '0;
      mat_b[e] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", {71'b0, in_ready}, 72'd1);
    chk("rst_arr_clr", {71'b0, arr_clr}, 72'd0);
    chk("rst_result_valid", {71'b0, result_valid}, 72'd0);
    chk("rst_arr_a", 72'(pack_a()), 72'd0);
    chk("rst_arr_b", 72'(pack_b()), 72'd0);
    chk("rst_result", pack_res(), 72'd0);

    // Identity multiply
    set_a_seq(1);
    set_b_ident();
    accept(1'b1);
    chk("ident_clr_after_accept", {71'b0, arr_clr}, 72'd1);
    finish_txn("ident");
    release_result();

    // Skew pattern, A = 1..9, B = 10..18
    set_a_seq(1);
    set_b_seq(10);
    accept(1'b1);
    chk("skew_clear_a", 72'(pack_a()), 72'd0);
    chk("skew_clear_b", 72'(pack_b()), 72'd0);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk("skew_t0_a", 72'(pack_a()), 72'({8'd1, 8'd0, 8'd0}));
        chk("skew_t0_b", 72'(pack_b()), 72'({8'd10, 8'd0, 8'd0}));
      end
      if (k == 3) begin
        chk("skew_t2_a", 72'(pack_a()), 72'({8'd3, 8'd5, 8'd7}));
        chk("skew_t2_b", 72'(pack_b()), 72'({8'd16, 8'd14, 8'd12}));
      end
      if (k == 5) begin
        chk("skew_t4_a", 72'(pack_a()), 72'({8'd0, 8'd0, 8'd9}));
        chk("skew_t4_b", 72'(pack_b()), 72'({8'd0, 8'd0, 8'd18}));
      end
      if (k >= 8 && k <= 10) begin
        chk("skew_drain_a", 72'(pack_a()), 72'd0);
        chk("skew_drain_b", 72'(pack_b()), 72'd0);
        chk("skew_drain_valid", {71'b0, result_valid}, 72'd0);
      end
    end
    chk("skew_valid_at_11", {71'b0, result_valid}, 72'd1);
    check_result("skew_result");

    // Backpressure with an ignored second matrix
    held = pack_res();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 10) begin
        set_fill(7, 7);
        load();
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("bp_result_stable", pack_res(), held);
      chk("bp_in_ready_low", {71'b0, in_ready}, 72'd0);
      chk("bp_valid_high", {71'b0, result_valid}, 72'd1);
    end
    in_valid = 1'b0;
    release_result();
    set_a_seq(2);
    set_b_ident();
    accept(1'b1);
    finish_txn("after_bp");
    release_result();

    // Back-to-back with result_ready tied high
    result_ready = 1'b1;
    set_a_seq(1);
    set_b_ident();
    accept(1'b1);
    finish_txn("b2b_first");
    set_fill(2, 1);
    accept(1'b1);
    finish_txn("b2b_second");

    // Reset during FEED step t=3
    set_a_seq(1);
    set_b_seq(10);
    accept(1'b1);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    void'(exp_q.pop_front());
    chk("midrst_in_ready", {71'b0, in_ready}, 72'd1);
    chk("midrst_arr_clr", {71'b0, arr_clr}, 72'd0);
    chk("midrst_arr_a", 72'(pack_a()), 72'd0);
    chk("midrst_arr_b", 72'(pack_b()), 72'd0);
    chk("midrst_valid", {71'b0, result_valid}, 72'd0);
    chk("midrst_result", pack_res(), 72'd0);
    set_a_seq(3);
    set_b_seq(10);
    accept(1'b1);
    finish_txn("post_rst");
    result_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
